// File: rtl/relay_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : relay_mem_pkg
//  Description : Shared types and default widths for the relay computer
//                synchronous memory (state encoding, bus/word widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package relay_mem_pkg;

    // Controller states: idle, streamed preload, read/write latency, bus hold
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RD_WAIT = 3'd2,
        WR_WAIT = 3'd3,
        HOLD    = 3'd4
    } mem_state_e;

    localparam int ADDR_WIDTH_DEFAULT     = 15;
    localparam int DATA_WIDTH_DEFAULT     = 8;
    localparam int BUS_ADDR_WIDTH_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/relay_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : relay_mem_array
//  Description : Single-port storage, synchronous write and asynchronous
//                read, 2**ADDR_WIDTH words of DATA_WIDTH bits. Not cleared
//                by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module relay_mem_array
    import relay_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // Commit a word on the clock edge when write enable is high
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/relay_memory_sync.sv
`default_nettype none
// ============================================================================
//  Module      : relay_memory_sync
//  Description : Clocked relay-computer memory. Serves MemRead/MemWrite bus
//                cycles with a fixed access latency, drives read data plus an
//                output enable for an external tristate driver, and accepts a
//                streamed preload of the whole array.
//  Revision    : 1.0 - initial release
// ============================================================================
module relay_memory_sync
    import relay_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
    parameter int BUS_ADDR_WIDTH = BUS_ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int ACCESS_CYCLES  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [BUS_ADDR_WIDTH-1:0] addr_bus,
    input  logic [DATA_WIDTH-1:0]     data_bus_in,
    output logic [DATA_WIDTH-1:0]     data_bus_out,
    output logic                      data_bus_oe,
    output logic                      ready,
    output logic                      access_error,
    input  logic                      load_start,
    input  logic                      load_valid,
    input  logic [DATA_WIDTH-1:0]     load_data,
    output logic                      load_ready,
    output logic                      load_complete
);

    // Wait counter holds ACCESS_CYCLES-1 down to 0
    localparam int c_WAIT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(ACCESS_CYCLES - 1);

    mem_state_e r_state;
    mem_state_e w_next_state;

    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_is_read;
    // One extra bit so reaching DEPTH is visible without wrapping to 0
    logic [ADDR_WIDTH:0]   r_load_cnt;

    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_oe;
    logic                  r_ready;
    logic                  r_access_error;
    logic                  r_load_ready;
    logic                  r_load_complete;

    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_oe_nxt;
    logic                  w_ready_nxt;
    logic                  w_access_error_nxt;
    logic                  w_load_ready_nxt;
    logic                  w_load_complete_nxt;

    logic                  w_both_req;
    logic                  w_any_req;
    logic                  w_wait_done;
    logic                  w_rd_done;
    logic                  w_wr_commit;
    logic                  w_hold_exit;
    logic                  w_load_restart;
    logic                  w_load_accept;
    logic                  w_load_last;
    logic                  w_accept_access;

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // Address bits above ADDR_WIDTH are deliberately ignored
    logic                  w_addr_unused;
    assign w_addr_unused = &{1'b0, addr_bus};

    assign w_both_req      = mem_read && mem_write;
    assign w_any_req       = mem_read || mem_write;
    assign w_wait_done     = (r_wait_cnt == '0);
    assign w_rd_done       = (r_state == RD_WAIT) && w_wait_done;
    assign w_wr_commit     = (r_state == WR_WAIT) && w_wait_done;
    assign w_hold_exit     = r_is_read ? !mem_read : !mem_write;
    assign w_load_restart  = load_start && ((r_state == IDLE) || (r_state == LOAD));
    assign w_load_accept   = (r_state == LOAD) && !load_start && load_valid && r_load_ready;
    assign w_load_last     = (r_load_cnt[ADDR_WIDTH-1:0] == '1);
    assign w_accept_access = (r_state == IDLE) && !load_start && !w_both_req && w_any_req;

    // Preload and bus writes share the single array port; reset blocks a
    // write that would otherwise land on the same edge.
    assign w_mem_we    = !reset && (w_load_accept || w_wr_commit);
    assign w_mem_addr  = (r_state == LOAD) ? r_load_cnt[ADDR_WIDTH-1:0] : r_addr;
    assign w_mem_wdata = (r_state == LOAD) ? load_data : r_wdata;

    relay_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clock),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // State register plus registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_data_out      <= '0;
            r_oe            <= 1'b0;
            r_ready         <= 1'b0;
            r_access_error  <= 1'b0;
            r_load_ready    <= 1'b0;
            r_load_complete <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_data_out      <= w_data_nxt;
            r_oe            <= w_oe_nxt;
            r_ready         <= w_ready_nxt;
            r_access_error  <= w_access_error_nxt;
            r_load_ready    <= w_load_ready_nxt;
            r_load_complete <= w_load_complete_nxt;
        end
    end

    // Latch the accepted request, run the latency counter and the load pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_read  <= 1'b0;
            r_load_cnt <= '0;
        end else begin
            if (w_accept_access) begin
                r_addr     <= addr_bus[ADDR_WIDTH-1:0];
                r_wdata    <= data_bus_in;
                r_is_read  <= mem_read;
                r_wait_cnt <= c_WAIT_INIT;
            end else if (((r_state == RD_WAIT) || (r_state == WR_WAIT)) && !w_wait_done) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end

            if (w_load_restart) begin
                r_load_cnt <= '0;
            end else if (w_load_accept) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end
        end
    end

    // Next-state selection; load_start outranks any bus request in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_next_state = LOAD;
                end else if (w_both_req) begin
                    w_next_state = IDLE;
                end else if (mem_read) begin
                    w_next_state = RD_WAIT;
                end else if (mem_write) begin
                    w_next_state = WR_WAIT;
                end
            end
            LOAD: begin
                if (w_load_accept && w_load_last) begin
                    w_next_state = IDLE;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (w_wait_done) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (w_hold_exit) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_ready_nxt        = w_rd_done || w_wr_commit;
        w_access_error_nxt = ((r_state == IDLE) && !load_start && w_both_req) ||
                             ((r_state == LOAD) && w_any_req);
        w_load_ready_nxt   = (w_next_state == LOAD);
        w_oe_nxt           = (w_next_state == HOLD) && r_is_read;

        w_data_nxt = '0;
        if (w_rd_done) begin
            w_data_nxt = w_mem_rdata;
        end else if (w_next_state == HOLD) begin
            w_data_nxt = r_data_out;
        end

        // Completion shows one cycle after the last word, once the pointer
        // has reached DEPTH; it stays set until the next load starts.
        w_load_complete_nxt = r_load_complete;
        if (w_load_restart) begin
            w_load_complete_nxt = 1'b0;
        end else if (r_load_cnt[ADDR_WIDTH]) begin
            w_load_complete_nxt = 1'b1;
        end
    end

    assign data_bus_out  = r_data_out;
    assign data_bus_oe   = r_oe;
    assign ready         = r_ready;
    assign access_error  = r_access_error;
    assign load_ready    = r_load_ready;
    assign load_complete = r_load_complete;

endmodule
`default_nettype wire
